// File: rtl/int2flt.sv
// ============================================================================
//  int2flt : sequential int16 -> IEEE-754 binary16 converter on a byte memory
//  Optional: INT2FLT_ROUND_EN selects round-to-nearest-even (else truncation)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module int2flt #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] IN_ADDR  = '0,
    parameter logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(2)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Done,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [7:0]        MemRdData,
    output logic              MemWrEn,
    output logic [7:0]        MemWrData
);

    localparam logic [ADDR_W-1:0] IN_ADDR_HI  = IN_ADDR + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OUT_ADDR_HI = OUT_ADDR + ADDR_W'(1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RD_LO = 4'd1;
    localparam logic [3:0] S_RD_HI = 4'd2;
    localparam logic [3:0] S_ABS   = 4'd3;
    localparam logic [3:0] S_NORM  = 4'd4;
    localparam logic [3:0] S_ROUND = 4'd5;
    localparam logic [3:0] S_WR_LO = 4'd6;
    localparam logic [3:0] S_WR_HI = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic        r_sign;
    logic [15:0] r_mag;
    logic [3:0]  r_k;
    logic [4:0]  r_exp;
    logic [9:0]  r_mant;

    logic [15:0] w_x;
    logic [15:0] w_abs;
    logic [9:0]  w_mant_tr;
    logic [4:0]  w_exp_tr;
    logic        w_round_up;
    logic [9:0]  w_mant_rnd;
    logic [4:0]  w_exp_rnd;

    // |x| never exceeds 32768, so 16 bits hold it exactly (0x8000 negates to itself)
    assign w_x       = {r_hi, r_lo};
    assign w_abs     = w_x[15] ? (16'd0 - w_x) : w_x;
    assign w_mant_tr = r_mag[14:5];
    assign w_exp_tr  = 5'd30 - {1'b0, r_k};

`ifdef INT2FLT_ROUND_EN
    assign w_round_up = r_mag[4] & ((|r_mag[3:0]) | r_mag[5]);
`else
    assign w_round_up = 1'b0;
`endif

    always_comb begin
        w_mant_rnd = w_mant_tr;
        w_exp_rnd  = w_exp_tr;
        if (w_round_up) begin
            if (&w_mant_tr) begin
                w_mant_rnd = '0;
                w_exp_rnd  = w_exp_tr + 5'd1;
            end else begin
                w_mant_rnd = w_mant_tr + 10'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (Start) w_next = S_RD_LO;
            S_RD_LO:        w_next = S_RD_HI;
            S_RD_HI:        w_next = S_ABS;
            S_ABS:          w_next = (w_x == 16'd0) ? S_WR_LO : S_NORM;
            S_NORM:         if (r_mag[15]) w_next = S_ROUND;
            S_ROUND:        w_next = S_WR_LO;
            S_WR_LO:        w_next = S_WR_HI;
            S_WR_HI:        w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_lo   <= '0;
            r_hi   <= '0;
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_k    <= '0;
            r_exp  <= '0;
            r_mant <= '0;
        end else begin
            case (r_state)
                S_RD_LO: r_lo <= MemRdData;
                S_RD_HI: r_hi <= MemRdData;
                S_ABS: begin
                    // zero leaves exp/mant cleared and skips straight to the writes
                    r_sign <= r_hi[7];
                    r_mag  <= w_abs;
                    r_k    <= '0;
                    r_exp  <= '0;
                    r_mant <= '0;
                end
                S_NORM: begin
                    if (!r_mag[15]) begin
                        r_mag <= {r_mag[14:0], 1'b0};
                        r_k   <= r_k + 4'd1;
                    end
                end
                S_ROUND: begin
                    r_exp  <= w_exp_rnd;
                    r_mant <= w_mant_rnd;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Done      = 1'b0;
        MemWrEn   = 1'b0;
        MemAddr   = '0;
        MemWrData = '0;
        case (r_state)
            S_RD_LO: MemAddr = IN_ADDR;
            S_RD_HI: MemAddr = IN_ADDR_HI;
            S_WR_LO: begin
                MemAddr   = OUT_ADDR;
                MemWrData = r_mant[7:0];
                MemWrEn   = 1'b1;
            end
            S_WR_HI: begin
                MemAddr   = OUT_ADDR_HI;
                MemWrData = {r_sign, r_exp, r_mant[9:8]};
                MemWrEn   = 1'b1;
            end
            S_DONE:  Done = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_int2flt.sv
// ============================================================================
//  tb_int2flt : scoreboard bench for int2flt (default and relocated instances)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_int2flt;

    logic       Clk    = 1'b0;
    logic       Reset  = 1'b1;
    logic       Start  = 1'b0;
    logic       Start2 = 1'b0;
    logic       Done, MemWrEn, Done2, MemWrEn2;
    logic [7:0] MemAddr, MemRdData, MemWrData;
    logic [7:0] MemAddr2, MemRdData2, MemWrData2;

    logic [7:0] in_mem  [256];
    logic [7:0] in_mem2 [256];
    logic [7:0] out_mem2[256];

    int checks = 0;
    int errors = 0;

    logic [15:0] sb_q[$];
    int          lat_q[$];

    int          wr_count = 0, bad_wr = 0, res_cnt = 0;
    int          wr_base = 0, res_base = 0;
    logic        prev_en = 1'b0;
    logic [7:0]  prev_addr = 8'd0, prev_data = 8'd0;
    logic [15:0] res_word = 16'd0;
    int          wr_count2 = 0, bad_wr2 = 0;

    logic [47:0] tbl[10] = '{
        48'h0000_0000_0000, 48'h0001_3C00_3C00, 48'hFFFE_C000_C000,
        48'h0801_6800_6800, 48'h0803_6802_6801, 48'h7FFF_7800_77FF,
        48'h8000_F800_F800, 48'hFFFF_BC00_BC00, 48'h0400_6400_6400,
        48'h00C0_5A00_5A00
    };

    always #5 Clk = ~Clk;

    assign MemRdData  = in_mem[MemAddr];
    assign MemRdData2 = in_mem2[MemAddr2];

    int2flt dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Done(Done),
        .MemAddr(MemAddr), .MemRdData(MemRdData),
        .MemWrEn(MemWrEn), .MemWrData(MemWrData)
    );

    int2flt #(.ADDR_W(8), .IN_ADDR(8'd4), .OUT_ADDR(8'd6)) dut2 (
        .Clk(Clk), .Reset(Reset), .Start(Start2), .Done(Done2),
        .MemAddr(MemAddr2), .MemRdData(MemRdData2),
        .MemWrEn(MemWrEn2), .MemWrData(MemWrData2)
    );

    always @(posedge Clk) begin
        prev_en   <= MemWrEn;
        prev_addr <= MemAddr;
        prev_data <= MemWrData;
        if (MemWrEn) begin
            wr_count <= wr_count + 1;
            if (MemAddr != 8'd2 && MemAddr != 8'd3) bad_wr <= bad_wr + 1;
            if (MemAddr == 8'd3 && prev_en && prev_addr == 8'd2) begin
                res_word <= {MemWrData, prev_data};
                res_cnt  <= res_cnt + 1;
            end
        end
        if (MemWrEn2) begin
            wr_count2 <= wr_count2 + 1;
            out_mem2[MemAddr2] <= MemWrData2;
            if (MemAddr2 != 8'd6 && MemAddr2 != 8'd7) bad_wr2 <= bad_wr2 + 1;
        end
    end

    // position of the leading one of |x|, -1 for zero
    function automatic int ref_p(input logic [15:0] x);
        int v, mag, p;
        v   = int'($signed(x));
        mag = (v < 0) ? -v : v;
        p   = -1;
        for (int i = 0; i < 17; i++) if (((mag >> i) & 1) == 1) p = i;
        return p;
    endfunction

    function automatic int ref_lat(input logic [15:0] x);
        int p;
        p = ref_p(x);
        return (p < 0) ? 5 : 22 - p;
    endfunction

    function automatic logic [15:0] ref_f16(input logic [15:0] x);
        int v, mag, p, sh, mant, e;
        logic [31:0] m32, e32;
        bit s;
        v   = int'($signed(x));
        s   = (v < 0);
        mag = s ? -v : v;
        p   = ref_p(x);
        if (p < 0) return 16'h0000;
        e = p + 15;
        if (p > 10) begin
            sh   = p - 10;
            mant = mag >> sh;
`ifdef INT2FLT_ROUND_EN
            begin
                int rem, half;
                rem  = mag & ((1 << sh) - 1);
                half = 1 << (sh - 1);
                if (rem > half || (rem == half && (mant & 1) == 1)) mant = mant + 1;
            end
`endif
            if (mant == 2048) begin
                mant = 1024;
                e    = e + 1;
            end
        end else begin
            mant = mag << (10 - p);
        end
        m32 = mant;
        e32 = e;
        return {s, e32[4:0], m32[9:0]};
    endfunction

    task automatic start_conv(input logic [15:0] x, input logic [15:0] exp_v,
                              input int exp_lat, input bit hold);
        in_mem[0] = x[7:0];
        in_mem[1] = x[15:8];
        sb_q.push_back(exp_v);
        lat_q.push_back(exp_lat);
        wr_base  = wr_count;
        res_base = res_cnt;
        Start    = 1'b1;
        @(negedge Clk);
        if (!hold) Start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int cyc;
        cyc = 0;
        while (Done !== 1'b1 && cyc < 40) begin
            @(negedge Clk);
            cyc++;
        end
        lat = cyc;
    endtask

    task automatic test_reset();
        #2 Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Done, MemWrEn, MemAddr, MemWrData} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {Done, MemWrEn, MemAddr, MemWrData});
        end
        checks++;
        if ({Done2, MemWrEn2, MemAddr2, MemWrData2} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs2 got=%h want=0", {Done2, MemWrEn2, MemAddr2, MemWrData2});
        end
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_convert();
        logic [15:0] x, e, got_exp;
        int lat, exp_l;
        for (int i = 0; i < 26; i++) begin
            if (i < 10) begin
                x = tbl[i][47:32];
`ifdef INT2FLT_ROUND_EN
                e = tbl[i][31:16];
`else
                e = tbl[i][15:0];
`endif
            end else begin
                x = 16'($urandom);
                e = ref_f16(x);
            end
            start_conv(x, e, ref_lat(x), 1'b0);
            wait_done(lat);
            got_exp = sb_q.pop_front();
            exp_l   = lat_q.pop_front();
            checks++;
            if (res_word !== got_exp || res_cnt - res_base != 1) begin
                errors++;
                $display("FAIL result x=%h got=%h want=%h pairs=%0d", x, res_word, got_exp, res_cnt - res_base);
            end
            checks++;
            if (lat != exp_l) begin
                errors++;
                $display("FAIL latency x=%h got=%0d want=%0d", x, lat, exp_l);
            end
            checks++;
            if (wr_count - wr_base != 2) begin
                errors++;
                $display("FAIL write_count x=%h got=%0d want=2", x, wr_count - wr_base);
            end
        end
        repeat (3) @(negedge Clk);
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL done_held got=%b want=1", Done);
        end
        checks++;
        if (bad_wr != 0) begin
            errors++;
            $display("FAIL stray_writes got=%0d want=0", bad_wr);
        end
    endtask

    task automatic test_ignore_start();
        logic [15:0] e;
        int lat, exp_l;
        start_conv(16'h0001, ref_f16(16'h0001), ref_lat(16'h0001), 1'b0);
        repeat (4) @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(lat);
        e     = sb_q.pop_front();
        exp_l = lat_q.pop_front();
        checks++;
        if (lat + 5 != exp_l) begin
            errors++;
            $display("FAIL ignore_latency got=%0d want=%0d", lat + 5, exp_l);
        end
        repeat (10) @(negedge Clk);
        checks++;
        if (wr_count - wr_base != 2 || res_cnt - res_base != 1 || res_word !== e) begin
            errors++;
            $display("FAIL ignore_writes writes=%0d res=%h want 2 writes res=%h", wr_count - wr_base, res_word, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] x1, x2, e;
        int lat, exp_l;
        x1 = 16'h0803;
        x2 = 16'hFFFE;
        start_conv(x1, ref_f16(x1), ref_lat(x1), 1'b1);
        wait_done(lat);
        e     = sb_q.pop_front();
        exp_l = lat_q.pop_front();
        checks++;
        if (lat != exp_l || res_word !== e || wr_count - wr_base != 2) begin
            errors++;
            $display("FAIL b2b_first lat=%0d res=%h writes=%0d want lat=%0d res=%h writes=2",
                     lat, res_word, wr_count - wr_base, exp_l, e);
        end
        in_mem[0] = x2[7:0];
        in_mem[1] = x2[15:8];
        sb_q.push_back(ref_f16(x2));
        lat_q.push_back(ref_lat(x2));
        wr_base  = wr_count;
        res_base = res_cnt;
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_pulse got=%b want=0", Done);
        end
        Start = 1'b0;
        wait_done(lat);
        e     = sb_q.pop_front();
        exp_l = lat_q.pop_front();
        checks++;
        if (lat != exp_l || res_word !== e || wr_count - wr_base != 2) begin
            errors++;
            $display("FAIL b2b_second lat=%0d res=%h writes=%0d want lat=%0d res=%h writes=2",
                     lat, res_word, wr_count - wr_base, exp_l, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        int lat, exp_l;
        start_conv(16'h0001, ref_f16(16'h0001), ref_lat(16'h0001), 1'b0);
        repeat (5) @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({Done, MemWrEn, MemAddr, MemWrData} !== 18'd0) begin
            errors++;
            $display("FAIL abort_outputs got=%h want=0", {Done, MemWrEn, MemAddr, MemWrData});
        end
        void'(sb_q.pop_back());
        void'(lat_q.pop_back());
        @(negedge Clk);
        Reset = 1'b1;
        repeat (30) @(negedge Clk);
        checks++;
        if (wr_count != wr_base || Done !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet writes=%0d done=%b want 0 writes done=0", wr_count - wr_base, Done);
        end
        start_conv(16'h0400, 16'h6400, ref_lat(16'h0400), 1'b0);
        wait_done(lat);
        e     = sb_q.pop_front();
        exp_l = lat_q.pop_front();
        checks++;
        if (res_word !== e || lat != exp_l || wr_count - wr_base != 2) begin
            errors++;
            $display("FAIL after_abort res=%h lat=%0d writes=%0d want res=%h lat=%0d writes=2",
                     res_word, lat, wr_count - wr_base, e, exp_l);
        end
    endtask

    task automatic test_addr_params();
        int cyc;
        for (int i = 0; i < 256; i++) in_mem2[i] = 8'h55;
        in_mem2[4] = 8'hC0;
        in_mem2[5] = 8'h00;
        Start2 = 1'b1;
        @(negedge Clk);
        Start2 = 1'b0;
        cyc = 0;
        while (Done2 !== 1'b1 && cyc < 40) begin
            @(negedge Clk);
            cyc++;
        end
        checks++;
        if (cyc != ref_lat(16'h00C0)) begin
            errors++;
            $display("FAIL addr_latency got=%0d want=%0d", cyc, ref_lat(16'h00C0));
        end
        checks++;
        if ({out_mem2[7], out_mem2[6]} !== 16'h5A00) begin
            errors++;
            $display("FAIL addr_result got=%h want=5a00", {out_mem2[7], out_mem2[6]});
        end
        checks++;
        if (wr_count2 != 2 || bad_wr2 != 0) begin
            errors++;
            $display("FAIL addr_writes count=%0d stray=%0d want 2 and 0", wr_count2, bad_wr2);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            in_mem[i]   = 8'(i * 37 + 11);
            in_mem2[i]  = 8'h55;
            out_mem2[i] = 8'hEE;
        end
        test_reset();
        test_convert();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_addr_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
